ask4_slicer: RTL
================

Name: ask4_slicer

Overview:
- Receive-side consumer of the pulse-shaping/matched filter output y. It is the opposite end of the sample-feed path that drives the filter input.
- Runs on sys_clk, gated by the sam_clk_en and sym_clk_en strobes from clk_en. Picks one sample per symbol at a programmable phase.
- Makes a 4-ASK decision against an adaptively estimated reference level. Reports the decided symbol, its ideal level, and the decision error.
- Publishes windowed reference and mean-squared-error statistics for the MER measurement path.

Parameters:
WIDTH, 18, sample width, signed 1s17
SPS, 4, samples per symbol (sam_clk_en pulses per sym_clk_en)
ACC_LOG2, 10, statistics window = 2^ACC_LOG2 decisions
REF_INIT, 18'd65536, ref_level after reset (ideal 2a for levels ±a, ±3a)

Ports:
sys_clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
sam_clk_en  in  1  sample-rate enable, one sys_clk wide
sym_clk_en  in  1  symbol-rate enable, always coincident with a sam_clk_en
phase  in  $clog2(SPS)  sample index within symbol used for decision
y_in  in  WIDTH signed  filter output
sym_out  out  2  decided symbol: 00=-3a, 01=-a, 10=+a, 11=+3a
sym_valid  out  1  one-cycle strobe, sym_out/mapped_out/err_out updated
mapped_out  out  WIDTH signed  ideal level of decided symbol
err_out  out  WIDTH signed  y_sample - mapped_out, saturated
ref_level  out  WIDTH unsigned  current decision reference (2a estimate)
mse_out  out  WIDTH unsigned  windowed mean of squared error
stats_valid  out  1  one-cycle strobe, ref_level/mse_out just updated

Behaviour:
- Reset (reset=0, async): sym_out=0, sym_valid=0, mapped_out=0, err_out=0, ref_level=REF_INIT, mse_out=0, stats_valid=0. Phase counter, capture register, accumulators and window counter are all cleared. A mid-window reset discards partial sums.
- Phase counter: on sam_clk_en, cnt <= (sym_clk_en) ? 1 : (cnt==SPS-1 ? 0 : cnt+1). The sample arriving with sym_clk_en is phase 0.
- Capture: at edge t where sam_clk_en=1 and the effective phase equals phase, ys <= y_in. Effective phase is 0 if sym_clk_en=1, else cnt. phase is sampled at the same edge; changing it takes effect on the next sample.
- Decision at edge t+1, uses ref_level as held at edge t+1 (before any same-edge update):
  - ys >= ref -> 11
  - 0 <= ys < ref -> 10
  - -ref <= ys < 0 -> 01
  - ys < -ref -> 00
- Mapped levels are ±(ref>>1) and ±(ref + (ref>>1)), computed 19-bit and saturated to [-131072, 131071].
- err_out = sat18(ys - mapped). sym_valid=1 during the cycle after edge t+1 only; otherwise 0. sym_out/mapped_out/err_out hold between strobes.
- Statistics, at each decision edge:
  - abs_acc += |ys|, with |-131072| saturated to 131071.
  - sq_acc += (err*err)>>>17 (17-bit magnitude).
  - Both accumulators are WIDTH+ACC_LOG2 bits wide and cannot overflow.
  - win_cnt increments.
- Window close: on the decision that makes win_cnt wrap 2^ACC_LOG2-1 -> 0, the following happen at the next edge (t+2):
  - ref_level <= abs_acc_final >> ACC_LOG2; a zero result is clamped to 1.
  - mse_out <= sq_acc_final >> ACC_LOG2.
  - Accumulators restart at 0; stats_valid pulses one cycle.
  - The decision of that window uses the old ref. The next decision uses the new ref.
- Latency: y_in at capture edge -> sym_out at +1 sys_clk edge; -> stats at +2.
- No decisions are made while sam_clk_en stays low; all outputs hold.

Decomposition:
- Package ask4_pkg holds:
  - WIDTH
  - symbol encodings SYM_M3, SYM_M1, SYM_P1, SYM_P3
  - SAT_MAX=131071, SAT_MIN=-131072
  - a sat18 function on 19-bit input
  - an abs18 function
- One natural sub-module, ask4_window_avg. It is a parameterised accumulate/count/shift unit: inputs value, en, reset; outputs avg, done. It is instantiated twice, once for |ys| and once for squared error.

Test Plan:
- Reset: hold reset=0 for 3 cycles, release -> all outputs 0, ref_level=65536, no sym_valid until the first phase-matching sam_clk_en.
- Decision levels, ref=65536, phase=0, SPS=4:
  - y=98304 -> sym 11, mapped 98304, err 0.
  - y=20000 -> 10, mapped 32768, err -12768.
  - y=-70000 -> 00, mapped -98304, err 28304.
- Phase select: y_in ramp 0,1000,2000,3000 per sample, phase=2 -> every decision captures 2000, sym 10. Exactly one sym_valid per 4 sam_clk_en.
- Adaptation, ACC_LOG2=2: four decisions with |ys|=40000 -> stats_valid once, ref_level=40000. The 5th decision on y=30000 gives sym 10, mapped 20000, err 10000.
- Saturation: y=-131072, ref=131071 -> sym 00, mapped -131072 (saturated), err 0, abs contribution 131071.
- Mid-window reset, ACC_LOG2=2: two decisions, pulse reset low -> ref_level returns to 65536, and the next stats_valid occurs only after 4 fresh decisions.

Source files
------------

// File: rtl/ask4_pkg.sv
// Shared types, constants and saturation helpers for the 4-ASK slicer.
// Latency: n/a (combinational helpers only).
// Backpressure: n/a.
package ask4_pkg;

    localparam int WIDTH = 18;

    // Symbol encodings, ordered by increasing amplitude.
    localparam logic [1:0] SYM_M3 = 2'b00;
    localparam logic [1:0] SYM_M1 = 2'b01;
    localparam logic [1:0] SYM_P1 = 2'b10;
    localparam logic [1:0] SYM_P3 = 2'b11;

    // Signed 1s17 extremes: +131071 / -131072.
    localparam logic signed [WIDTH-1:0] SAT_MAX = 18'sh1FFFF;
    localparam logic signed [WIDTH-1:0] SAT_MIN = 18'sh20000;

    // Clamp a 19-bit signed value into the 18-bit signed range.
    function automatic logic signed [WIDTH-1:0] sat18(input logic signed [WIDTH:0] x);
        if (x[WIDTH] != x[WIDTH-1]) begin
            return x[WIDTH] ? SAT_MIN : SAT_MAX;
        end
        return x[WIDTH-1:0];
    endfunction

    // Magnitude of an 18-bit signed value; the most negative code maps to +max.
    function automatic logic [WIDTH-1:0] abs18(input logic signed [WIDTH-1:0] x);
        if (x == SAT_MIN) begin
            return SAT_MAX;
        end
        if (x[WIDTH-1]) begin
            return WIDTH'(-x);
        end
        return x;
    endfunction

endpackage

// File: rtl/ask4_window_avg.sv
// Accumulates 2^ACC_LOG2 enabled samples and presents their mean with a done strobe.
// Latency: done/avg valid the cycle after the enable that completes a window.
// Backpressure: none; every en is consumed, next window restarts when done is seen.
module ask4_window_avg #(
    parameter int W        = 18,
    parameter int ACC_LOG2 = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] value,
    output logic [W-1:0] avg,
    output logic         done
);

    localparam int AW = W + ACC_LOG2;

    logic [AW-1:0]       acc_q, acc_d;
    logic [ACC_LOG2-1:0] cnt_q, cnt_d;
    logic                done_q, done_d;
    logic [AW-1:0]       base;

    // Accumulate; the cycle after a window closes the sum is dropped and restarts.
    always_comb begin
        base   = done_q ? '0 : acc_q;
        acc_d  = base;
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (en) begin
            acc_d  = base + AW'(value);
            cnt_d  = cnt_q + 1'b1;
            done_d = &cnt_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    // While done is high acc_q holds the completed window sum.
    assign avg  = W'(acc_q >> ACC_LOG2);
    assign done = done_q;

endmodule

// File: rtl/ask4_slicer.sv
// 4-ASK symbol slicer: picks one sample per symbol, decides against an adaptive reference.
// Latency: capture edge -> decision +1 sys_clk, -> statistics update +2 sys_clk.
// Backpressure: none; driven purely by sam_clk_en/sym_clk_en strobes, outputs hold otherwise.
module ask4_slicer
    import ask4_pkg::*;
#(
    parameter int               SPS      = 4,
    parameter int               ACC_LOG2 = 10,
    parameter logic [WIDTH-1:0] REF_INIT = 18'd65536
) (
    input  logic                       sys_clk,
    input  logic                       reset,
    input  logic                       sam_clk_en,
    input  logic                       sym_clk_en,
    input  logic [$clog2(SPS)-1:0]     phase,
    input  logic signed [WIDTH-1:0]    y_in,
    output logic [1:0]                 sym_out,
    output logic                       sym_valid,
    output logic signed [WIDTH-1:0]    mapped_out,
    output logic signed [WIDTH-1:0]    err_out,
    output logic [WIDTH-1:0]           ref_level,
    output logic [WIDTH-1:0]           mse_out,
    output logic                       stats_valid
);

    localparam int PW = $clog2(SPS);

    logic [PW-1:0]             cnt_q, cnt_d;
    logic [PW-1:0]             eff_phase;
    logic signed [WIDTH-1:0]   ys_q, ys_d;
    logic                      cap_q, cap_d;
    logic [1:0]                sym_q, sym_d;
    logic                      sym_valid_q, sym_valid_d;
    logic signed [WIDTH-1:0]   mapped_q, mapped_d;
    logic signed [WIDTH-1:0]   err_q, err_d;
    logic [WIDTH-1:0]          ref_q, ref_d;
    logic [WIDTH-1:0]          mse_q, mse_d;
    logic                      stats_valid_q, stats_valid_d;

    logic signed [WIDTH+1:0]   ys_x, ref_x;
    logic signed [WIDTH:0]     half19, three19;
    logic signed [WIDTH-1:0]   lv_p3, lv_p1, lv_m1, lv_m3;
    logic [1:0]                dec_sym;
    logic signed [WIDTH-1:0]   dec_lvl;
    logic signed [WIDTH-1:0]   dec_err;
    logic signed [2*WIDTH-1:0] err_sq;
    logic [WIDTH-1:0]          sq_val;
    logic [WIDTH-1:0]          abs_val;
    logic [WIDTH-1:0]          abs_avg, sq_avg;
    logic                      abs_done, sq_done, win_done;

    // Symbol-phase counter and single-sample capture at the selected phase.
    always_comb begin
        cnt_d     = cnt_q;
        ys_d      = ys_q;
        cap_d     = 1'b0;
        eff_phase = sym_clk_en ? '0 : cnt_q;
        if (sam_clk_en) begin
            if (sym_clk_en) begin
                cnt_d = PW'(1);
            end else if (cnt_q == PW'(SPS - 1)) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            if (eff_phase == phase) begin
                ys_d  = y_in;
                cap_d = 1'b1;
            end
        end
    end

    // Ideal levels +-ref/2 and +-3ref/2, and the slicer decision on the captured sample.
    always_comb begin
        ys_x    = WIDTH'(0) + {{2{ys_q[WIDTH-1]}}, ys_q};
        ref_x   = $signed({2'b00, ref_q});
        half19  = $signed({2'b00, ref_q[WIDTH-1:1]});
        three19 = $signed({1'b0, ref_q}) + half19;
        lv_p3   = sat18(three19);
        lv_p1   = sat18(half19);
        lv_m1   = sat18(-half19);
        lv_m3   = sat18(-three19);
        if (ys_x >= ref_x) begin
            dec_sym = SYM_P3;
            dec_lvl = lv_p3;
        end else if (!ys_q[WIDTH-1]) begin
            dec_sym = SYM_P1;
            dec_lvl = lv_p1;
        end else if (ys_x >= -ref_x) begin
            dec_sym = SYM_M1;
            dec_lvl = lv_m1;
        end else begin
            dec_sym = SYM_M3;
            dec_lvl = lv_m3;
        end
        dec_err = sat18({ys_q[WIDTH-1], ys_q} - {dec_lvl[WIDTH-1], dec_lvl});
        err_sq  = dec_err * dec_err;
        sq_val  = WIDTH'(err_sq >>> 17);
        abs_val = abs18(ys_q);
    end

    // Register the decision one edge after capture; strobe sym_valid for that cycle.
    always_comb begin
        sym_d       = sym_q;
        mapped_d    = mapped_q;
        err_d       = err_q;
        sym_valid_d = cap_q;
        if (cap_q) begin
            sym_d    = dec_sym;
            mapped_d = dec_lvl;
            err_d    = dec_err;
        end
    end

    ask4_window_avg #(.W(WIDTH), .ACC_LOG2(ACC_LOG2)) u_abs_avg (
        .clk   (sys_clk),
        .rst_n (reset),
        .en    (cap_q),
        .value (abs_val),
        .avg   (abs_avg),
        .done  (abs_done)
    );

    ask4_window_avg #(.W(WIDTH), .ACC_LOG2(ACC_LOG2)) u_sq_avg (
        .clk   (sys_clk),
        .rst_n (reset),
        .en    (cap_q),
        .value (sq_val),
        .avg   (sq_avg),
        .done  (sq_done)
    );

    // Both windows count the same decisions, so their done strobes coincide.
    assign win_done = abs_done & sq_done;

    // Publish window statistics; a zero reference would collapse all levels, so clamp to 1.
    always_comb begin
        ref_d         = ref_q;
        mse_d         = mse_q;
        stats_valid_d = win_done;
        if (win_done) begin
            ref_d = (abs_avg == '0) ? WIDTH'(1) : abs_avg;
            mse_d = sq_avg;
        end
    end

    // State registers.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            cnt_q         <= '0;
            ys_q          <= '0;
            cap_q         <= 1'b0;
            sym_q         <= '0;
            sym_valid_q   <= 1'b0;
            mapped_q      <= '0;
            err_q         <= '0;
            ref_q         <= REF_INIT;
            mse_q         <= '0;
            stats_valid_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            ys_q          <= ys_d;
            cap_q         <= cap_d;
            sym_q         <= sym_d;
            sym_valid_q   <= sym_valid_d;
            mapped_q      <= mapped_d;
            err_q         <= err_d;
            ref_q         <= ref_d;
            mse_q         <= mse_d;
            stats_valid_q <= stats_valid_d;
        end
    end

    assign sym_out     = sym_q;
    assign sym_valid   = sym_valid_q;
    assign mapped_out  = mapped_q;
    assign err_out     = err_q;
    assign ref_level   = ref_q;
    assign mse_out     = mse_q;
    assign stats_valid = stats_valid_q;

endmodule
